// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Round-robin grant, operands registered onto the ALU, result captured after
//   EXEC_CYCLES cycles and returned on a valid/ready channel tagged with the id.
// Parameters:
//   EXEC_CYCLES  cycles the operands are held on the ALU before capture (1..15)
// Ports:
//   clk, rst                           clock, synchronous active-high reset
//   req0_* / req1_*                    valid/ready request channels (opcode, a, b)
//   alu_opcode, alu_a, alu_b           registered ALU inputs
//   alu_salida, alu_flags              ALU result and flags
//   rsp_valid, rsp_ready               response handshake
//   rsp_id, rsp_salida, rsp_flags      response payload
// Optional build macro ALU_ARB_STATS_EN:
//   done_cnt0, done_cnt1               saturating per-requester completion counts
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [2:0] req0_opcode,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [2:0] req1_opcode,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_salida,
  input  logic [7:0] alu_flags,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_salida,
  output logic [7:0] rsp_flags
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0] done_cnt0,
  output logic [7:0] done_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_e     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic       id_q, id_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] opc_q, opc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] sal_q, sal_d;
  logic [7:0] flg_q, flg_d;
  logic       gnt0, gnt1;
  logic       done;

  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~ptr_q);
    gnt1 = req1_valid & (~req0_valid | ptr_q);
    // ready is masked during reset so a requester never sees a handshake
    // that the reset then discards.
    req0_ready = (state_q == IDLE) & ~rst & gnt0;
    req1_ready = (state_q == IDLE) & ~rst & gnt1;

    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    opc_d       = opc_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    sal_d       = sal_q;
    flg_d       = flg_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0_ready | req1_ready) begin
          id_d    = req1_ready;
          opc_d   = req1_ready ? req1_opcode : req0_opcode;
          a_d     = req1_ready ? req1_a      : req0_a;
          b_d     = req1_ready ? req1_b      : req0_b;
          cnt_d   = CNT_INIT;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          sal_d       = alu_salida;
          flg_d       = alu_flags;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_valid_q & rsp_ready) begin
          rsp_valid_d = 1'b0;
          ptr_d       = ~id_q;
          done        = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      cnt_q       <= '0;
      opc_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      sal_q       <= '0;
      flg_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      opc_q       <= opc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      sal_q       <= sal_d;
      flg_q       <= flg_d;
    end
  end

  assign alu_opcode = opc_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_salida = sal_q;
  assign rsp_flags  = flg_q;

`ifdef ALU_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else if (done) begin
      if (!id_q && cnt0_q != '1) cnt0_q <= cnt0_q + 8'd1;
      if (id_q && cnt1_q != '1)  cnt1_q <= cnt1_q + 8'd1;
    end
  end

  assign done_cnt0 = cnt0_q;
  assign done_cnt1 = cnt1_q;
`else
  logic unused_done;
  assign unused_done = done;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: two instances (EXEC_CYCLES = 1 and 4) driven with
// directed and random stimulus, checked every cycle against a transaction-level
// reference model. Stats outputs are checked when ALU_ARB_STATS_EN is defined.
module tb_alu_arbiter;

  localparam int P_RST = 0, P_SINGLE = 1, P_CONT = 2, P_BP = 3, P_MID = 4,
                 P_RAND = 5, P_STAT = 6;

  logic       clk;
  logic       rst;
  logic       req0_valid[2], req1_valid[2], req0_ready[2], req1_ready[2];
  logic [2:0] req0_opcode[2], req1_opcode[2], alu_opcode[2];
  logic [7:0] req0_a[2], req0_b[2], req1_a[2], req1_b[2];
  logic [7:0] alu_a[2], alu_b[2], alu_salida[2], alu_flags[2];
  logic       rsp_valid[2], rsp_ready[2], rsp_id[2];
  logic [7:0] rsp_salida[2], rsp_flags[2];
`ifdef ALU_ARB_STATS_EN
  logic [7:0] done_cnt0[2], done_cnt1[2];
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int phase = P_RST;

  // reference model state, per instance
  logic       m_busy[2], m_ptr[2], m_id[2];
  logic [2:0] m_opc[2];
  logic [7:0] m_a[2], m_b[2], m_sal[2], m_flg[2];
  int         m_acc[2], m_cnt0[2], m_cnt1[2];
  logic       q_id[$];
  logic [7:0] q_sal[$];

  // behavioural ALU: {flags, salida}; flags = {0000, carry, neg, zero, parity}
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [7:0] a,
                                        input logic [7:0] b);
    logic [8:0] r;
    case (op)
      3'd0: r = {1'b0, a & b};
      3'd1: r = {1'b0, a | b};
      3'd2: r = {1'b0, a} + {1'b0, b};
      3'd3: r = {1'b0, a} - {1'b0, b};
      3'd4: r = {1'b0, a << b[2:0]};
      3'd5: r = {1'b0, a >> b[2:0]};
      3'd6: r = {1'b0, a ^ b};
      default: r = {1'b0, ~a};
    endcase
    return {4'b0, r[8], r[7], r[7:0] == 8'd0, ^r[7:0], r[7:0]};
  endfunction

  function automatic int ex(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [15:0] alu_out;
    assign alu_out       = alu_f(alu_opcode[g], alu_a[g], alu_b[g]);
    assign alu_salida[g] = alu_out[7:0];
    assign alu_flags[g]  = alu_out[15:8];

    alu_arbiter #(.EXEC_CYCLES((g == 0) ? 1 : 4)) u_dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid[g]), .req0_ready(req0_ready[g]),
      .req0_opcode(req0_opcode[g]), .req0_a(req0_a[g]), .req0_b(req0_b[g]),
      .req1_valid(req1_valid[g]), .req1_ready(req1_ready[g]),
      .req1_opcode(req1_opcode[g]), .req1_a(req1_a[g]), .req1_b(req1_b[g]),
      .alu_opcode(alu_opcode[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
      .alu_salida(alu_salida[g]), .alu_flags(alu_flags[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]), .rsp_id(rsp_id[g]),
      .rsp_salida(rsp_salida[g]), .rsp_flags(rsp_flags[g])
`ifdef ALU_ARB_STATS_EN
      , .done_cnt0(done_cnt0[g]), .done_cnt1(done_cnt1[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_busy[k] = 0; m_ptr[k] = 0; m_id[k] = 0;
    m_opc[k] = 0; m_a[k] = 0; m_b[k] = 0; m_sal[k] = 0; m_flg[k] = 0;
    m_acc[k] = 0; m_cnt0[k] = 0; m_cnt1[k] = 0;
  endtask

  task automatic drive(input int ph, input int c);
    for (int k = 0; k < 2; k++) begin
      rst = 1'b0;
      rsp_ready[k] = 1'b1;
      req0_valid[k] = 1'b0; req1_valid[k] = 1'b0;
      req0_opcode[k] = 3'($urandom); req0_a[k] = 8'($urandom); req0_b[k] = 8'($urandom);
      req1_opcode[k] = 3'($urandom); req1_a[k] = 8'($urandom); req1_b[k] = 8'($urandom);
      case (ph)
        P_RST: rst = 1'b1;
        P_SINGLE: begin
          req0_valid[k] = (c == 0);
          req0_opcode[k] = 3'd2; req0_a[k] = 8'd5; req0_b[k] = 8'd3;
        end
        P_CONT: begin
          req0_valid[k] = 1'b1; req1_valid[k] = 1'b1;
          req0_opcode[k] = 3'd3; req0_a[k] = 8'd9; req0_b[k] = 8'd4;
          req1_opcode[k] = 3'd2; req1_a[k] = 8'd1; req1_b[k] = 8'd1;
        end
        P_BP: begin
          req0_valid[k] = (c < 20);
          req1_valid[k] = (c >= 1 && c < 20);
          rsp_ready[k] = (c >= 12 + ex(k));
        end
        P_MID: begin
          req0_valid[k] = (c == 0) || (c >= 3);
          req1_valid[k] = (c >= 3);
          rst = (c == 2);
        end
        P_RAND: begin
          rst = ($urandom_range(0, 99) == 0);
          req0_valid[k] = $urandom_range(0, 1) == 1;
          req1_valid[k] = $urandom_range(0, 1) == 1;
          rsp_ready[k] = $urandom_range(0, 9) < 7;
        end
        P_STAT: req0_valid[k] = 1'b1;
        default: ;
      endcase
    end
  endtask

  // compare the sampled outputs with the model, then advance the model by one edge
  task automatic step(input int k);
    logic g0, g1, vis, e_r0, e_r1;
    logic [15:0] res;
    string s;
    s = $sformatf("[%0d]", k);
    g0 = req0_valid[k] && (!req1_valid[k] || !m_ptr[k]);
    g1 = req1_valid[k] && (!req0_valid[k] || m_ptr[k]);
    vis = m_busy[k] && (cyc >= m_acc[k] + 1 + ex(k));
    e_r0 = !rst && !m_busy[k] && g0;
    e_r1 = !rst && !m_busy[k] && g1;
    res = alu_f(m_opc[k], m_a[k], m_b[k]);
    chk({"req0_ready", s}, 32'(req0_ready[k]), 32'(e_r0));
    chk({"req1_ready", s}, 32'(req1_ready[k]), 32'(e_r1));
    chk({"alu_opcode", s}, 32'(alu_opcode[k]), 32'(m_opc[k]));
    chk({"alu_a", s}, 32'(alu_a[k]), 32'(m_a[k]));
    chk({"alu_b", s}, 32'(alu_b[k]), 32'(m_b[k]));
    chk({"rsp_valid", s}, 32'(rsp_valid[k]), 32'(vis));
    if (vis) chk({"rsp_id", s}, 32'(rsp_id[k]), 32'(m_id[k]));
    chk({"rsp_salida", s}, 32'(rsp_salida[k]), 32'(vis ? res[7:0] : m_sal[k]));
    chk({"rsp_flags", s}, 32'(rsp_flags[k]), 32'(vis ? res[15:8] : m_flg[k]));
`ifdef ALU_ARB_STATS_EN
    chk({"done_cnt0", s}, 32'(done_cnt0[k]), 32'(m_cnt0[k]));
    chk({"done_cnt1", s}, 32'(done_cnt1[k]), 32'(m_cnt1[k]));
`endif
    if (rst) begin
      model_reset(k);
    end else if (!m_busy[k] && (g0 || g1)) begin
      m_busy[k] = 1; m_id[k] = g1; m_acc[k] = cyc;
      m_opc[k] = g1 ? req1_opcode[k] : req0_opcode[k];
      m_a[k]   = g1 ? req1_a[k] : req0_a[k];
      m_b[k]   = g1 ? req1_b[k] : req0_b[k];
    end else if (vis && rsp_ready[k]) begin
      m_busy[k] = 0; m_ptr[k] = !m_id[k];
      m_sal[k] = res[7:0]; m_flg[k] = res[15:8];
      if (m_id[k]) m_cnt1[k] = (m_cnt1[k] < 255) ? m_cnt1[k] + 1 : 255;
      else         m_cnt0[k] = (m_cnt0[k] < 255) ? m_cnt0[k] + 1 : 255;
      if (phase == P_CONT && k == 0) begin
        q_id.push_back(m_id[k]);
        q_sal.push_back(res[7:0]);
      end
    end
  endtask

  task automatic run(input int ph, input int n);
    phase = ph;
    for (int c = 0; c < n; c++) begin
      drive(ph, c);
      @(negedge clk);
      step(0);
      step(1);
      cyc++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    drive(P_RST, 0);
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    run(P_RST, 3);
    run(P_SINGLE, 8);
    run(P_RST, 2);
    run(P_CONT, 30);
    chk("cont_count", 32'(q_id.size() >= 4), 32'd1);
    if (q_id.size() >= 4) begin
      chk("cont_id0", 32'(q_id[0]), 32'd0);
      chk("cont_id1", 32'(q_id[1]), 32'd1);
      chk("cont_id2", 32'(q_id[2]), 32'd0);
      chk("cont_id3", 32'(q_id[3]), 32'd1);
      chk("cont_sal0", 32'(q_sal[0]), 32'd5);
      chk("cont_sal1", 32'(q_sal[1]), 32'd2);
    end
    run(P_BP, 30);
    run(P_MID, 12);
    run(P_RAND, 2000);
`ifdef ALU_ARB_STATS_EN
    run(P_RST, 2);
    run(P_STAT, 2000);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stat_sat0[%0d]", k), 32'(done_cnt0[k]), 32'd255);
      chk($sformatf("stat_sat1[%0d]", k), 32'(done_cnt1[k]), 32'd0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one combinational `alu` instance (8-bit, 3-bit opcode, `salida`/`flags` outputs) between two requesters. Arbitration is round-robin. Each operation is sequenced through a fixed settle window, and `salida`/`flags` are returned over a valid/ready response channel tagged with the requester id. It sits between the two operand sources and the `alu`, and registers all ALU inputs and the captured result.

## Interface
- `EXEC_CYCLES`, default 1: cycles operands are held on the ALU before capture; legal range 1–15.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req0_valid`  in  1  requester 0 has an operation.
- `req0_ready`  out  1  requester 0 accepted this cycle.
- `req0_opcode`  in  3  requester 0 ALU opcode.
- `req0_a`, `req0_b`  in  8 each  requester 0 operands.
- `req1_valid`, `req1_ready`, `req1_opcode`, `req1_a`, `req1_b`: same as requester 0, for requester 1.
- `alu_opcode`  out  3  registered opcode to the `alu`.
- `alu_a`, `alu_b`  out  8 each  registered operands to the `alu`.
- `alu_salida`  in  8  `alu` result.
- `alu_flags`  in  8  `alu` flags.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  requester that issued the operation.
- `rsp_salida`, `rsp_flags`  out  8 each  captured result and flags.

## Operation
- FSM states: IDLE, EXEC, RESP.
- Reset: state IDLE; priority pointer 0 (requester 0 preferred); all outputs 0; counter 0.
- **IDLE, grant:**
  - `reqN_ready` is combinational and asserted only in IDLE, only for the granted requester.
  - Grant goes to the only valid requester. If both are valid, grant goes to the pointer's requester.
  - On handshake: load `alu_*` from the granted request, store its id, load counter with `EXEC_CYCLES-1`, go to EXEC.
- **EXEC:**
  - `alu_*` held stable.
  - While counter > 0, decrement it.
  - At counter = 0: capture `alu_salida`/`alu_flags` into `rsp_salida`/`rsp_flags`, set `rsp_valid`, go to RESP.
- **RESP:**
  - `rsp_*` held stable while `rsp_valid` is high and `rsp_ready` is low.
  - On `rsp_valid & rsp_ready`: clear `rsp_valid`, set pointer to the requester other than `rsp_id`, go to IDLE.
- `alu_*` keep their last value after completion; they change only on the next accept.
- A requester may drop `valid` before acceptance. Nothing is latched and no response is produced.
- Request fields are sampled only on the handshake edge.
- Only one operation is in flight; no request is accepted in EXEC or RESP.

## Timing
- Accept at edge of cycle T.
- `alu_*` valid from cycle T+1.
- `rsp_valid` high from cycle T+1+`EXEC_CYCLES`.
- Earliest next `ready`: cycle after the response handshake.
- Minimum period per operation: `EXEC_CYCLES`+2 cycles (with `rsp_ready` tied high).
- `rst` in any state takes effect at the next edge: pending operation discarded, no response, pointer returns to 0, counters cleared.
- `rst` and a handshake in the same cycle: reset wins; no operation accepted.

## Configuration
- `ALU_ARB_STATS_EN` defined:
  - Adds outputs `done_cnt0` and `done_cnt1`, 8 bits each: completed response handshakes per requester.
  - Saturating at 255.
  - Cleared by `rst`.
- Not defined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Single request: reset, `req0` opcode 010, A=5, B=3, `EXEC_CYCLES`=1, `rsp_ready`=1 → `req0_ready` in cycle 0, `rsp_valid` in cycle 2, `rsp_id`=0, `rsp_salida`=8, `rsp_flags` = `alu_flags` at capture.
- Simultaneous contention: both valid every cycle from reset, `req0` 011 A=9 B=4, `req1` 010 A=1 B=1 → responses alternate id 0 (salida 5), 1 (salida 2), 0, 1.
- Response backpressure: `rsp_ready`=0 for 10 cycles after `rsp_valid` → `rsp_*` stable, both `ready`s low throughout; completes the cycle `rsp_ready` rises.
- Settle window: `EXEC_CYCLES`=4, `req1` 100 A=1 B=3 → `rsp_valid` exactly 5 cycles after accept, `rsp_salida`=8.
- Reset mid-operation: `rst` pulsed in the second EXEC cycle → no `rsp_valid`, outputs 0, next simultaneous request grants requester 0.
- With `ALU_ARB_STATS_EN` defined: 300 completed requests from `req0` → `done_cnt0`=255, `done_cnt1`=0.
